// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
// Byte-serial controller sharing one 8-bit synchronous RAM port between MEM (priority) and IF.
// Define MEM_CTRL_MISALIGN_CHK_EN to reject misaligned MEM half/word accesses without a RAM cycle.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_enable,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [1:0]        mem_type,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              misalign,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                rw_q, rw_d;
  logic                own_mem_q, own_mem_d;
  logic [CNT_W-1:0]    size_q, size_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_wr_q, ram_wr_d;
  logic [7:0]          ram_dout_q, ram_dout_d;
  logic                mem_req;
  logic [DATA_W-1:0]   asm_word;
  logic [7:0]          nxt_byte;
`ifdef MEM_CTRL_MISALIGN_CHK_EN
  logic                misal_q, misal_d;
  logic                mis_acc;
`endif

  function automatic logic [CNT_W-1:0] type_size(input logic [1:0] t);
    case (t)
      2'd1:    type_size = 3'd1;
      2'd2:    type_size = 3'd2;
      default: type_size = 3'd4;
    endcase
  endfunction

  assign mem_req = mem_enable & (mem_type != 2'd0);

`ifdef MEM_CTRL_MISALIGN_CHK_EN
  assign mis_acc = ((mem_type == 2'd2) & mem_addr[0]) |
                   ((mem_type == 2'd3) & (mem_addr[1:0] != 2'b00));
`endif

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    own_mem_d  = own_mem_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mem_data_d = mem_data_q;
    if_data_d  = if_data_q;
    ram_addr_d = ram_addr_q;
    ram_wr_d   = 1'b0;
    ram_dout_d = ram_dout_q;
    busy       = 1'b0;
`ifdef MEM_CTRL_MISALIGN_CHK_EN
    misal_d    = misal_q;
`endif

    // Read byte k arrives while the counter reads k+1; merge it into the partial word.
    asm_word = rdata_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (i == int'(cnt_q) - 1) asm_word[8*i +: 8] = ram_din;
    end
    nxt_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (i == int'(cnt_q) + 1) nxt_byte = wdata_q[8*i +: 8];
    end

    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          busy      = 1'b1;
          own_mem_d = 1'b1;
          rw_d      = mem_rw;
          wdata_d   = mem_wdata;
          size_d    = type_size(mem_type);
          cnt_d     = '0;
          rdata_d   = '0;
`ifdef MEM_CTRL_MISALIGN_CHK_EN
          misal_d   = 1'b0;
          if (mis_acc) begin
            misal_d    = 1'b1;
            mem_data_d = '0;
            state_d    = S_DONE;
          end else
`endif
          begin
            state_d    = S_ACCESS;
            ram_addr_d = mem_addr;
            ram_wr_d   = mem_rw;
            if (mem_rw) ram_dout_d = mem_wdata[7:0];
          end
        end else if (if_req) begin
          own_mem_d  = 1'b0;
          rw_d       = 1'b0;
          size_d     = 3'd4;
          cnt_d      = '0;
          rdata_d    = '0;
          state_d    = S_ACCESS;
          ram_addr_d = if_addr;
        end
      end

      S_ACCESS: begin
        busy  = own_mem_q;
        cnt_d = cnt_q + 3'd1;
        if (rw_q) begin
          if ((cnt_q + 3'd1) < size_q) begin
            ram_addr_d = ram_addr_q + ADDR_W'(1);
            ram_wr_d   = 1'b1;
            ram_dout_d = nxt_byte;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          rdata_d = asm_word;
          if ((cnt_q + 3'd1) < size_q) ram_addr_d = ram_addr_q + ADDR_W'(1);
          if (cnt_q == size_q) begin
            state_d = S_DONE;
            if (own_mem_q) mem_data_d = asm_word;
            else           if_data_d  = asm_word;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b0;
      own_mem_q  <= 1'b0;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= '0;
      mem_data_q <= '0;
      if_data_q  <= '0;
`ifdef MEM_CTRL_MISALIGN_CHK_EN
      misal_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      own_mem_q  <= own_mem_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_wr_q   <= ram_wr_d;
      ram_dout_q <= ram_dout_d;
      mem_data_q <= mem_data_d;
      if_data_q  <= if_data_d;
`ifdef MEM_CTRL_MISALIGN_CHK_EN
      misal_q    <= misal_d;
`endif
    end
    size_q  <= size_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  // The strobe is masked by rst so a reset cycle never commits a further byte.
  assign ram_wr   = ram_wr_q & ~rst;
  assign ram_addr = ram_addr_q;
  assign ram_dout = ram_dout_q;
  assign mem_data = mem_data_q;
  assign if_data  = if_data_q;
  assign if_done  = (state_q == S_DONE) & ~own_mem_q;
`ifdef MEM_CTRL_MISALIGN_CHK_EN
  assign misalign = (state_q == S_DONE) & misal_q;
`else
  assign misalign = 1'b0;
`endif

endmodule
